multicycle_main_control: RTL and testbench
==========================================

MULTICYCLE_MAIN_CONTROL -- requirements
Module: multicycle_main_control

Interface
REQ-001 Parameter: MEM_WAIT_EN, default 1; 1 = memory states hold until mem_ready, 0 = mem_ready ignored (treated as 1).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  6  instruction[31:26] from instruction register, sampled in DECODE.
REQ-005 mem_ready  input  1  memory handshake; access completes in the cycle it is high.
REQ-006 mem_read, mem_write  output  1 each  memory read / write request.
REQ-007 iord  output  1  0 = PC addresses memory, 1 = ALUOut addresses memory.
REQ-008 ir_write, pc_write, pc_write_cond, reg_write  output  1 each  write enables.
REQ-009 reg_dst, mem_to_reg, alu_src_a  output  1 each  datapath mux selects.
REQ-010 alu_src_b  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
REQ-011 alu_op  output  2  to ALU control: 00 add, 01 subtract, 10 decode funct, 11 logical-immediate op.
REQ-012 pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-013 illegal_op  output  1  one-cycle pulse on unsupported opcode.
REQ-014 state_o  output  4  current state encoding, debug only.

Function
REQ-015 Block SHALL be a Moore FSM; every output SHALL be a pure decode of the state register and mem_ready, with unlisted outputs 0.
REQ-016 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, ALUWB, BEQ, IEX, IWB, JMP.
REQ-017 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write and pc_write SHALL equal mem_ready; SHALL move to DECODE only when mem_ready=1, else hold.
REQ-018 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute); next state by opcode: 100011/101011->MEMADR, 000000->REX, 000100->BEQ, 001000/001100->IEX, 000010->JMP.
REQ-019 Any other opcode in DECODE SHALL go to FETCH and pulse illegal_op for exactly that DECODE cycle.
REQ-020 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEMRD for 100011, MEMWR for 101011.
REQ-021 MEMRD: mem_read=1, iord=1; advance to MEMWB on mem_ready, else hold.
REQ-022 MEMWR: mem_write=1, iord=1; advance to FETCH on mem_ready, else hold.
REQ-023 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; next FETCH.
REQ-024 REX: alu_src_a=1, alu_src_b=00, alu_op=10; next ALUWB (reg_write=1, reg_dst=1, mem_to_reg=0), then FETCH.
REQ-025 BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01; next FETCH.
REQ-026 IEX: alu_src_a=1, alu_src_b=10; alu_op=00 for 001000, 11 for 001100, opcode value captured in DECODE; next IWB (reg_write=1, reg_dst=0, mem_to_reg=0), then FETCH.
REQ-027 JMP: pc_write=1, pc_src=10; next FETCH.
REQ-028 Zero-wait latencies in cycles: lw 5, sw 4, R-type 4, addi/andi 4, beq 3, j 3; each mem_ready-low cycle adds one.
REQ-029 mem_read and mem_write SHALL never be asserted together; only one write enable class per state as listed.
REQ-030 Illegal/unreachable state encodings SHALL transition to FETCH on next edge with all outputs 0.

Reset
REQ-031 rst_n low SHALL immediately force state FETCH and all write enables, mem_read, mem_write, illegal_op to 0, regardless of clk.
REQ-032 First rising edge after rst_n rises SHALL execute FETCH normally; reset mid-instruction SHALL abandon it with no write asserted.

Structure
REQ-033 Shared package mc_ctrl_pkg SHALL hold the state enum, opcode constants, ALUOp and alu_src_b/pc_src encodings.
REQ-034 One sub-module mc_ctrl_outdec (state -> control word, combinational) is natural; next-state logic stays in the top.

Verification
REQ-035 lw (100011), mem_ready=1 always -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; reg_write=1, mem_to_reg=1 in cycle 5 only.
REQ-036 R-type (000000) -> alu_op=10 in REX, reg_write=1 with reg_dst=1 in ALUWB; 4 cycles total.
REQ-037 sw with mem_ready low 3 cycles in MEMWR -> mem_write held 4 cycles, then FETCH; reg_write never 1.
REQ-038 opcode 111111 -> illegal_op=1 for one cycle, next state FETCH, no write enables.
REQ-039 rst_n dropped mid-MEMRD, asynchronous to clk -> outputs 0 within same cycle, state_o=FETCH encoding.
REQ-040 beq (000100) then andi (001100) -> pc_write_cond=1, alu_op=01 in BEQ; alu_op=11 in IEX.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle main control FSM:
// state enum, opcodes, ALUOp / mux-select encodings and the control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_IEX    = 4'd9,
    S_IWB    = 4'd10,
    S_JMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LOGI  = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;
  } ctrl_word_t;

  function automatic logic opcode_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_LW, OP_SW: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state -> control word decode. Unused state codes and
// unlisted fields decode to zero.
import mc_ctrl_pkg::*;

module mc_ctrl_outdec (
  input  state_t     state,
  input  logic       mem_ready,
  input  logic       imm_logic,
  input  logic       op_illegal,
  output ctrl_word_t ctrl
);

  // Per-state control word; every field defaults to zero first.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SH;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = op_illegal;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_REX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PCSRC_ALUOUT;
      end
      S_IEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        if (imm_logic) begin
          ctrl.alu_op = ALUOP_LOGI;
        end else begin
          ctrl.alu_op = ALUOP_ADD;
        end
      end
      S_IWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_JMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle MIPS-style main control: Moore FSM with next-state logic here
// and output decode in mc_ctrl_outdec.
import mc_ctrl_pkg::*;

module multicycle_main_control #(
  parameter int MEM_WAIT_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  state_t     state_r;
  state_t     state_next_s;
  logic [5:0] opcode_r;
  logic       mem_ready_eff_s;
  ctrl_word_t ctrl_raw_s;
  ctrl_word_t ctrl_s;

  assign mem_ready_eff_s = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

  // State register plus the opcode latched in DECODE for later states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_FETCH;
      opcode_r <= 6'b000000;
    end else begin
      state_r <= state_next_s;
      if (state_r == S_DECODE) begin
        opcode_r <= opcode;
      end else begin
        opcode_r <= opcode_r;
      end
    end
  end

  // Next-state logic; memory states stall on mem_ready.
  always_comb begin
    state_next_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        if (mem_ready_eff_s) begin
          state_next_s = S_DECODE;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:     state_next_s = S_MEMADR;
          OP_RTYPE:         state_next_s = S_REX;
          OP_BEQ:           state_next_s = S_BEQ;
          OP_ADDI, OP_ANDI: state_next_s = S_IEX;
          OP_J:             state_next_s = S_JMP;
          default:          state_next_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode_r == OP_SW) begin
          state_next_s = S_MEMWR;
        end else begin
          state_next_s = S_MEMRD;
        end
      end
      S_MEMRD: begin
        if (mem_ready_eff_s) begin
          state_next_s = S_MEMWB;
        end else begin
          state_next_s = S_MEMRD;
        end
      end
      S_MEMWR: begin
        if (mem_ready_eff_s) begin
          state_next_s = S_FETCH;
        end else begin
          state_next_s = S_MEMWR;
        end
      end
      S_REX:   state_next_s = S_ALUWB;
      S_IEX:   state_next_s = S_IWB;
      S_MEMWB, S_ALUWB, S_BEQ, S_IWB, S_JMP: state_next_s = S_FETCH;
      default: state_next_s = S_FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state      (state_r),
    .mem_ready  (mem_ready_eff_s),
    .imm_logic  (opcode_r == OP_ANDI),
    .op_illegal (~opcode_legal(opcode)),
    .ctrl       (ctrl_raw_s)
  );

  // Reset blanks the control word immediately, not just at the next edge.
  assign ctrl_s = rst_n ? ctrl_raw_s : '0;

  assign mem_read      = ctrl_s.mem_read;
  assign mem_write     = ctrl_s.mem_write;
  assign iord          = ctrl_s.iord;
  assign ir_write      = ctrl_s.ir_write;
  assign pc_write      = ctrl_s.pc_write;
  assign pc_write_cond = ctrl_s.pc_write_cond;
  assign reg_write     = ctrl_s.reg_write;
  assign reg_dst       = ctrl_s.reg_dst;
  assign mem_to_reg    = ctrl_s.mem_to_reg;
  assign alu_src_a     = ctrl_s.alu_src_a;
  assign alu_src_b     = ctrl_s.alu_src_b;
  assign alu_op        = ctrl_s.alu_op;
  assign pc_src        = ctrl_s.pc_src;
  assign illegal_op    = ctrl_s.illegal_op;
  assign state_o       = state_r;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: expected control words are
// queued as stimulus is driven and compared at the following falling edge.
import mc_ctrl_pkg::*;

module tb_multicycle_main_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state_o;
  logic [20:0] obs;
  logic [20:0] sb_q[$];
  int n_tests;
  int n_fail;

  multicycle_main_control #(.MEM_WAIT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .illegal_op(illegal_op), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {state_o, mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
                illegal_op};

  // Reference control word for a state, straight from the state table.
  function automatic logic [20:0] ev(input state_t s, input logic mr,
                                     input logic lg, input logic ill);
    logic rd, wr, io, irw, pcw, pwc, rw, rdst, m2r, sa, il;
    logic [1:0] sb, op, ps;
    {rd, wr, io, irw, pcw, pwc, rw, rdst, m2r, sa, il} = 11'b0;
    sb = 2'b00; op = 2'b00; ps = 2'b00;
    case (s)
      S_FETCH:  begin rd = 1'b1; sb = 2'b01; irw = mr; pcw = mr; end
      S_DECODE: begin sb = 2'b11; il = ill; end
      S_MEMADR: begin sa = 1'b1; sb = 2'b10; end
      S_MEMRD:  begin rd = 1'b1; io = 1'b1; end
      S_MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
      S_MEMWR:  begin wr = 1'b1; io = 1'b1; end
      S_REX:    begin sa = 1'b1; op = 2'b10; end
      S_ALUWB:  begin rw = 1'b1; rdst = 1'b1; end
      S_BEQ:    begin sa = 1'b1; op = 2'b01; pwc = 1'b1; ps = 2'b01; end
      S_IEX:    begin sa = 1'b1; sb = 2'b10; op = lg ? 2'b11 : 2'b00; end
      S_IWB:    begin rw = 1'b1; end
      S_JMP:    begin pcw = 1'b1; ps = 2'b10; end
      default:  begin rd = 1'b0; end
    endcase
    return {s, rd, wr, io, irw, pcw, pwc, rw, rdst, m2r, sa, sb, op, ps, il};
  endfunction

  task automatic check_pop(input string tag);
    logic [20:0] e;
    e = sb_q.pop_front();
    n_tests++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  // One clock cycle: drive inputs, queue expectation, compare at negedge.
  task automatic cyc(input logic [5:0] op, input logic mr, input logic [20:0] e,
                     input string tag);
    opcode = op;
    mem_ready = mr;
    sb_q.push_back(e);
    @(negedge clk);
    check_pop(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst_n = 1'b0;
    opcode = 6'b000000;
    mem_ready = 1'b0;

    #3;
    sb_q.push_back({S_FETCH, 17'b0});
    check_pop("reset_state");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // lw, zero wait: 5 cycles
    cyc(OP_LW, 1'b1, ev(S_FETCH, 1'b1, 1'b0, 1'b0), "lw_fetch");
    cyc(OP_LW, 1'b1, ev(S_DECODE, 1'b1, 1'b0, 1'b0), "lw_decode");
    cyc(OP_LW, 1'b1, ev(S_MEMADR, 1'b1, 1'b0, 1'b0), "lw_memadr");
    cyc(OP_LW, 1'b1, ev(S_MEMRD, 1'b1, 1'b0, 1'b0), "lw_memrd");
    cyc(OP_LW, 1'b1, ev(S_MEMWB, 1'b1, 1'b0, 1'b0), "lw_memwb");

    // sw with a fetch stall and three MEMWR stall cycles
    cyc(OP_SW, 1'b0, ev(S_FETCH, 1'b0, 1'b0, 1'b0), "sw_fetch_wait");
    cyc(OP_SW, 1'b1, ev(S_FETCH, 1'b1, 1'b0, 1'b0), "sw_fetch");
    cyc(OP_SW, 1'b1, ev(S_DECODE, 1'b1, 1'b0, 1'b0), "sw_decode");
    cyc(OP_SW, 1'b1, ev(S_MEMADR, 1'b1, 1'b0, 1'b0), "sw_memadr");
    for (int i = 0; i < 3; i++)
      cyc(OP_SW, 1'b0, ev(S_MEMWR, 1'b0, 1'b0, 1'b0), "sw_memwr_wait");
    cyc(OP_SW, 1'b1, ev(S_MEMWR, 1'b1, 1'b0, 1'b0), "sw_memwr");

    // R-type
    cyc(OP_RTYPE, 1'b1, ev(S_FETCH, 1'b1, 1'b0, 1'b0), "r_fetch");
    cyc(OP_RTYPE, 1'b1, ev(S_DECODE, 1'b1, 1'b0, 1'b0), "r_decode");
    cyc(OP_RTYPE, 1'b1, ev(S_REX, 1'b1, 1'b0, 1'b0), "r_rex");
    cyc(OP_RTYPE, 1'b1, ev(S_ALUWB, 1'b1, 1'b0, 1'b0), "r_aluwb");

    // illegal opcode: pulse in DECODE only, then straight back to FETCH
    cyc(6'b111111, 1'b1, ev(S_FETCH, 1'b1, 1'b0, 1'b0), "ill_fetch");
    cyc(6'b111111, 1'b1, ev(S_DECODE, 1'b1, 1'b0, 1'b1), "ill_decode");

    // beq then andi then addi then j
    cyc(OP_BEQ, 1'b1, ev(S_FETCH, 1'b1, 1'b0, 1'b0), "beq_fetch");
    cyc(OP_BEQ, 1'b1, ev(S_DECODE, 1'b1, 1'b0, 1'b0), "beq_decode");
    cyc(OP_BEQ, 1'b1, ev(S_BEQ, 1'b1, 1'b0, 1'b0), "beq_exec");
    cyc(OP_ANDI, 1'b1, ev(S_FETCH, 1'b1, 1'b0, 1'b0), "andi_fetch");
    cyc(OP_ANDI, 1'b1, ev(S_DECODE, 1'b1, 1'b0, 1'b0), "andi_decode");
    cyc(6'b000000, 1'b1, ev(S_IEX, 1'b1, 1'b1, 1'b0), "andi_iex");
    cyc(6'b000000, 1'b1, ev(S_IWB, 1'b1, 1'b1, 1'b0), "andi_iwb");
    cyc(OP_ADDI, 1'b1, ev(S_FETCH, 1'b1, 1'b0, 1'b0), "addi_fetch");
    cyc(OP_ADDI, 1'b1, ev(S_DECODE, 1'b1, 1'b0, 1'b0), "addi_decode");
    cyc(OP_ADDI, 1'b1, ev(S_IEX, 1'b1, 1'b0, 1'b0), "addi_iex");
    cyc(OP_ADDI, 1'b1, ev(S_IWB, 1'b1, 1'b0, 1'b0), "addi_iwb");
    cyc(OP_J, 1'b1, ev(S_FETCH, 1'b1, 1'b0, 1'b0), "j_fetch");
    cyc(OP_J, 1'b1, ev(S_DECODE, 1'b1, 1'b0, 1'b0), "j_decode");
    cyc(OP_J, 1'b1, ev(S_JMP, 1'b1, 1'b0, 1'b0), "j_exec");

    // lw stalled in MEMRD, then reset mid-cycle
    cyc(OP_LW, 1'b1, ev(S_FETCH, 1'b1, 1'b0, 1'b0), "lw2_fetch");
    cyc(OP_LW, 1'b1, ev(S_DECODE, 1'b1, 1'b0, 1'b0), "lw2_decode");
    cyc(OP_LW, 1'b1, ev(S_MEMADR, 1'b1, 1'b0, 1'b0), "lw2_memadr");
    cyc(OP_LW, 1'b0, ev(S_MEMRD, 1'b0, 1'b0, 1'b0), "lw2_memrd_wait");
    mem_ready = 1'b0;
    sb_q.push_back({S_FETCH, 17'b0});
    #2;
    rst_n = 1'b0;
    #1;
    check_pop("async_reset_mid_memrd");
    mem_ready = 1'b1;
    sb_q.push_back({S_FETCH, 17'b0});
    @(posedge clk);
    #1;
    check_pop("reset_held_over_edge");
    rst_n = 1'b1;
    cyc(OP_RTYPE, 1'b1, ev(S_FETCH, 1'b1, 1'b0, 1'b0), "post_reset_fetch");
    cyc(OP_RTYPE, 1'b1, ev(S_DECODE, 1'b1, 1'b0, 1'b0), "post_reset_decode");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
